// File: rtl/capture_buffer_if.sv
// ============================================================================
// capture_buffer_if : DMA-side read port and transfer handshake of capture_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

interface capture_buffer_if;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        dma_ready;
  logic        dma_enable;

  modport master (
    output rd_addr,
    output dma_ready,
    input  rd_data,
    input  dma_enable
  );

  modport slave (
    input  rd_addr,
    input  dma_ready,
    output rd_data,
    output dma_enable
  );
endinterface

`default_nettype wire

// File: rtl/capture_buffer.sv
// ============================================================================
// capture_buffer : armed/triggered decimating 4x16-bit sample recorder into BRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module capture_buffer #(
  parameter int DEPTH_WORDS = 16384,
  parameter int DECIM_W     = 16,
  parameter int PRE_W       = 14
) (
  input  logic                aclk,
  input  logic                rst_ni,
  input  logic signed [15:0]  ch0_i,
  input  logic signed [15:0]  ch1_i,
  input  logic signed [15:0]  ch2_i,
  input  logic signed [15:0]  ch3_i,
  input  logic                sample_vld_i,
  input  logic                arm_i,
  input  logic                trig_i,
  input  logic [DECIM_W-1:0]  decim_i,
  input  logic [PRE_W-1:0]    pretrig_i,
  capture_buffer_if.slave     dma,
  output logic [1:0]          state_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    POST = 2'b10,
    XFER = 2'b11
  } state_e;

  localparam int                 CNT_W      = PRE_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PRE_W-1:0]   PTR_ONE    = PRE_W'(1);
  localparam logic [DECIM_W-1:0] DEC_ONE    = DECIM_W'(1);
  localparam logic [2:0]         EN_CYCLES  = 3'd4;

  state_e             state_q, state_d;
  logic               arm_q, trig_q;
  logic [DECIM_W-1:0] dec_q, dec_d;
  logic [PRE_W-1:0]   pretrig_q, pretrig_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
  logic [PRE_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PRE_W-1:0]   start_q, start_d;
  logic [2:0]         en_cnt_q, en_cnt_d;
  logic               low_seen_q, low_seen_d;
  logic [63:0]        rd_data_q;

  logic [63:0]        mem [DEPTH_WORDS];

  logic               arm_edge, trig_edge, keep, wr_en, rd_oob;
  logic [63:0]        word;
  logic [PRE_W-1:0]   phys;

  // Edge history follows the pins even in reset, so a level held across reset is not an edge.
  assign arm_edge  = arm_i  & ~arm_q;
  assign trig_edge = trig_i & ~trig_q;
  assign keep      = sample_vld_i && (dec_q == decim_i);
  assign wr_en     = rst_ni && keep && ((state_q == PRE) || (state_q == POST));
  assign word      = {ch3_i, ch2_i, ch1_i, ch0_i};
  assign phys      = dma.rd_addr[PRE_W-1:0] + start_q;
  assign rd_oob    = (dma.rd_addr >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    pretrig_d  = pretrig_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    start_d    = start_q;
    en_cnt_d   = en_cnt_q;
    low_seen_d = low_seen_q;

    if (sample_vld_i) begin
      dec_d = keep ? '0 : dec_q + DEC_ONE;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case (state_q)
      IDLE: begin
        if (arm_edge) begin
          state_d   = PRE;
          pretrig_d = pretrig_i;
          wr_ptr_d  = '0;
          pre_cnt_d = '0;
          dec_d     = '0;
        end
      end
      PRE: begin
        if (keep && (pre_cnt_q != pretrig_q)) begin
          pre_cnt_d = pre_cnt_q + PTR_ONE;
        end
        if (trig_edge && (pre_cnt_q == pretrig_q)) begin
          state_d    = POST;
          post_cnt_d = DEPTH_CNT - {1'b0, pretrig_q};
        end
      end
      POST: begin
        if (keep) begin
          post_cnt_d = post_cnt_q - CNT_ONE;
          if (post_cnt_q == CNT_ONE) begin
            state_d    = XFER;
            // The slot after the final write holds the oldest word of the ring.
            start_d    = wr_ptr_q + PTR_ONE;
            en_cnt_d   = '0;
            low_seen_d = 1'b0;
          end
        end
      end
      XFER: begin
        if (en_cnt_q != EN_CYCLES) begin
          en_cnt_d = en_cnt_q + 3'd1;
        end
        if (!dma.dma_ready) begin
          low_seen_d = 1'b1;
        end
        if (low_seen_q && dma.dma_ready && (en_cnt_q == EN_CYCLES)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    arm_q  <= arm_i;
    trig_q <= trig_i;
    if (!rst_ni) begin
      state_q    <= IDLE;
      dec_q      <= '0;
      pretrig_q  <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      wr_ptr_q   <= '0;
      start_q    <= '0;
      en_cnt_q   <= '0;
      low_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      pretrig_q  <= pretrig_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      start_q    <= start_d;
      en_cnt_q   <= en_cnt_d;
      low_seen_q <= low_seen_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_oob ? 64'd0 : mem[phys];
    end
  end

  assign dma.rd_data    = rd_data_q;
  assign dma.dma_enable = (state_q == XFER) && (en_cnt_q != EN_CYCLES);
  assign state_o        = state_q;
  assign busy_o         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_capture_buffer.sv
// ============================================================================
// tb_capture_buffer : scoreboard bench for capture_buffer (1024-word record)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_capture_buffer;
  localparam int DEPTH = 1024;
  localparam int PW    = 10;
  localparam int DW    = 16;

  logic          aclk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [15:0]   ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
  logic          vld = 1'b0, arm = 1'b0, trig = 1'b0;
  logic [DW-1:0] decim = '0;
  logic [PW-1:0] pretrig = '0;
  logic [1:0]    state;
  logic          busy;

  capture_buffer_if dma_if();

  capture_buffer #(.DEPTH_WORDS(DEPTH), .DECIM_W(DW), .PRE_W(PW)) dut (
    .aclk         (aclk),
    .rst_ni       (rst_ni),
    .ch0_i        (ch0),
    .ch1_i        (ch1),
    .ch2_i        (ch2),
    .ch3_i        (ch3),
    .sample_vld_i (vld),
    .arm_i        (arm),
    .trig_i       (trig),
    .decim_i      (decim),
    .pretrig_i    (pretrig),
    .dma          (dma_if),
    .state_o      (state),
    .busy_o       (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [63:0] hist[$];
  logic [63:0] exp_q[$];
  int m_state = 0, m_dcnt = 0, m_pre = 0, m_post = 0, m_pretrig = 0;

  function automatic logic [63:0] make_word(input int n);
    logic [15:0] v;
    v = n[15:0];
    return {v ^ 16'h5a5a, v + 16'd1, ~v, v};
  endfunction

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_sample(input int n);
    logic [15:0] v;
    v = n[15:0];
    ch0 = v; ch1 = ~v; ch2 = v + 16'd1; ch3 = v ^ 16'h5a5a;
    vld = 1'b1;
    if (m_dcnt == int'(decim)) begin
      m_dcnt = 0;
      if (m_state == 1 || m_state == 2) begin
        hist.push_back(make_word(n));
        if (m_state == 1 && m_pre < m_pretrig) m_pre++;
        if (m_state == 2) begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
    end else begin
      m_dcnt++;
    end
    cyc();
    vld = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(); arm = 1'b0; cyc();
    if (m_state == 0) begin
      m_state = 1; m_dcnt = 0; m_pre = 0; m_pretrig = int'(pretrig);
      hist.delete();
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1; cyc(); trig = 1'b0; cyc();
    if (m_state == 1 && m_pre == m_pretrig) begin
      m_state = 2; m_post = DEPTH - m_pretrig;
    end
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0; cyc(); cyc(); rst_ni = 1'b1; m_state = 0;
  endtask

  task automatic finish_dma();
    dma_if.dma_ready = 1'b0; cyc(); cyc();
    dma_if.dma_ready = 1'b1; cyc();
    if (m_state == 3) m_state = 0;
  endtask

  task automatic count_enable(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (dma_if.dma_enable) n++;
      cyc();
    end
  endtask

  // Scoreboard: expected record pushed from the write history, popped per read address.
  task automatic read_record(output int nbad, output int bad_addr,
                             output logic [63:0] bad_got, output logic [63:0] bad_want);
    int first;
    logic [63:0] want;
    exp_q.delete();
    first = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0;
    for (int i = first; i < hist.size(); i++) exp_q.push_back(hist[i]);
    nbad = 0; bad_addr = -1; bad_got = '0; bad_want = '0;
    for (int a = 0; a < DEPTH; a++) begin
      dma_if.rd_addr = a;
      cyc();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      if (dma_if.rd_data !== want) begin
        if (nbad == 0) begin
          bad_addr = a; bad_got = dma_if.rd_data; bad_want = want;
        end
        nbad++;
      end
    end
    dma_if.rd_addr = '0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; arm = 1'b1;
    cyc(); cyc(); cyc();
    rst_ni = 1'b1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dma_if.rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", dma_if.rd_data); end
    checks++; if (dma_if.dma_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", dma_if.dma_enable); end
    cyc(); cyc(); cyc();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_arm_no_capture: got %0d want 0", state); end
    arm = 1'b0; cyc();
    arm = 1'b1; cyc();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rearm_capture: got %0d want 1", state); end
    arm = 1'b0;
    reset_dut();
  endtask

  task automatic test_no_decim();
    int nbad, ba, nen; logic [63:0] bg, bw;
    decim = '0; pretrig = '0;
    pulse_arm();
    pulse_trig();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL nodecim_trig_immediate: got %0d want 2", state); end
    for (int n = 0; n < DEPTH - 1; n++) drive_sample(n);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL nodecim_still_post: got %0d want 2", state); end
    drive_sample(DEPTH - 1);
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL nodecim_xfer: got %0d want 3", state); end
    count_enable(nen);
    checks++; if (nen !== 4) begin errors++; $display("FAIL nodecim_enable_cycles: got %0d want 4", nen); end
    read_record(nbad, ba, bg, bw);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL nodecim_record: %0d bad, addr %0d got %h want %h", nbad, ba, bg, bw); end
    dma_if.dma_ready = 1'b0; cyc(); cyc();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL nodecim_wait_done: got %0d want 3", state); end
    dma_if.dma_ready = 1'b1; cyc();
    if (m_state == 3) m_state = 0;
    checks++; if (state !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL nodecim_idle: got state %0d busy %b want 0 0", state, busy); end
  endtask

  task automatic test_decim();
    int nbad, ba, n; logic [63:0] bg, bw;
    decim = 16'd3; pretrig = 10'd100;
    pulse_arm();
    for (n = 0; n < 400; n++) drive_sample(n);
    pulse_trig();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL decim_trig: got %0d want 2", state); end
    while (m_state != 3 && n < 400 + 4 * DEPTH + 8) begin
      drive_sample(n);
      n++;
    end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL decim_xfer: got %0d want 3", state); end
    dma_if.rd_addr = 99; cyc();
    checks++; if (dma_if.rd_data !== make_word(399)) begin errors++; $display("FAIL decim_last_pre: got %h want %h", dma_if.rd_data, make_word(399)); end
    dma_if.rd_addr = 100; cyc();
    checks++; if (dma_if.rd_data !== make_word(403)) begin errors++; $display("FAIL decim_first_post: got %h want %h", dma_if.rd_data, make_word(403)); end
    read_record(nbad, ba, bg, bw);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL decim_record: %0d bad, addr %0d got %h want %h", nbad, ba, bg, bw); end
    finish_dma();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL decim_idle: got %0d want 0", state); end
  endtask

  task automatic test_early_trig();
    int nbad, ba; logic [63:0] bg, bw;
    decim = '0; pretrig = 10'd100;
    pulse_arm();
    for (int n = 0; n < 50; n++) drive_sample(n);
    pulse_trig();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL early_trig_ignored: got %0d want 1", state); end
    for (int n = 50; n < 100; n++) drive_sample(n);
    pulse_trig();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL late_trig_accepted: got %0d want 2", state); end
    for (int n = 100; n < DEPTH; n++) drive_sample(n);
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL early_xfer: got %0d want 3", state); end
    read_record(nbad, ba, bg, bw);
    checks++; if (nbad !== 0) begin errors++; $display("FAIL early_record: %0d bad, addr %0d got %h want %h", nbad, ba, bg, bw); end
    finish_dma();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL early_idle: got %0d want 0", state); end
  endtask

  task automatic test_oob_and_reset();
    dma_if.rd_addr = DEPTH; cyc();
    checks++; if (dma_if.rd_data !== 64'd0) begin errors++; $display("FAIL oob_depth: got %h want 0", dma_if.rd_data); end
    dma_if.rd_addr = 32'hFFFF_FFFF; cyc();
    checks++; if (dma_if.rd_data !== 64'd0) begin errors++; $display("FAIL oob_max: got %h want 0", dma_if.rd_data); end
    dma_if.rd_addr = DEPTH - 1; cyc();
    checks++; if (dma_if.rd_data !== make_word(DEPTH - 1)) begin errors++; $display("FAIL last_addr: got %h want %h", dma_if.rd_data, make_word(DEPTH - 1)); end
    dma_if.rd_addr = '0;
    decim = '0; pretrig = '0;
    pulse_arm();
    pulse_trig();
    for (int n = 0; n < 10; n++) drive_sample(n);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL midpost_state: got %0d want 2", state); end
    rst_ni = 1'b0; cyc();
    checks++; if (state !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL midpost_reset: got state %0d busy %b want 0 0", state, busy); end
    rst_ni = 1'b1; m_state = 0; cyc();
  endtask

  initial begin
    dma_if.rd_addr   = '0;
    dma_if.dma_ready = 1'b1;
    test_reset();
    test_no_decim();
    test_decim();
    test_early_trig();
    test_oob_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
